// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter
// Description : Parametrised up/down Gray-code counter with synchronous
//               clear, Gray-coded parallel load, sticky overflow/underflow
//               flags and a one-cycle wrap pulse. The binary count is the
//               state; the Gray output is registered alongside it so the
//               two always agree and no input reaches an output
//               combinationally.
//
//               Optional build macro:
//                 GRAY_SAT_EN  - saturating mode: a count request at the
//                                terminal value is refused (count holds),
//                                the matching flag is set and wrap_o pulses.
//                                Undefined (default): modulo wrap.
//
// Ports       : clk_i        rising-edge clock
//               rst_n_i      asynchronous active-low reset
//               clear_i      synchronous clear to INIT_BIN, clears flags
//               load_i       synchronous load of load_val_i
//               load_val_i   Gray-coded load value   [WIDTH]
//               en_i         count enable
//               up_i         direction when enabled (1 = up, 0 = down)
//               count_o      registered Gray count    [WIDTH]
//               bin_o        registered binary count  [WIDTH]
//               wrap_o       one-cycle registered wrap pulse
//               overflow_o   sticky, set on up-wrap
//               underflow_o  sticky, set on down-wrap
//
// Revision    : 1.0  initial release
// ============================================================================
module gray_counter #(
  parameter int WIDTH    = 3,
  parameter int INIT_BIN = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             wrap_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam logic [WIDTH-1:0] INIT_VAL  = WIDTH'(INIT_BIN);
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_VAL ^ (INIT_VAL >> 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q,  ovf_d;
  logic             udf_q,  udf_d;
  logic [WIDTH-1:0] load_bin;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above
  // it. Written as a reduction per bit so no bit depends on another.
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(load_val_i >> i);
    end
  end

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (clear_i) begin
      bin_d = INIT_VAL;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else if (load_i) begin
      bin_d = load_bin;
    end else if (en_i) begin
      if (up_i) begin
        if (bin_q == ALL_ONES) begin
          ovf_d  = 1'b1;
          wrap_d = 1'b1;
`ifdef GRAY_SAT_EN
          bin_d  = bin_q;
`else
          bin_d  = '0;
`endif
        end else begin
          bin_d = bin_q + ONE;
        end
      end else begin
        if (bin_q == '0) begin
          udf_d  = 1'b1;
          wrap_d = 1'b1;
`ifdef GRAY_SAT_EN
          bin_d  = bin_q;
`else
          bin_d  = ALL_ONES;
`endif
        end else begin
          bin_d = bin_q - ONE;
        end
      end
    end
    // Gray is derived from the next binary value so both register together.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bin_q  <= INIT_VAL;
      gray_q <= INIT_GRAY;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign count_o     = gray_q;
  assign bin_o       = bin_q;
  assign wrap_o      = wrap_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_counter
// Description : Self-checking bench for gray_counter (WIDTH=3, INIT_BIN=0).
//               Directed scenarios plus randomized traffic compared against
//               an integer-valued reference model of the counter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gray_counter;

  localparam int W    = 3;
  localparam int INIT = 0;
  localparam int M    = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         up;
  logic [W-1:0] count;
  logic [W-1:0] bin;
  logic         wrap;
  logic         ovf;
  logic         udf;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: plain integer count and flag bits.
  int unsigned m_val;
  bit          m_ovf;
  bit          m_udf;
  bit          m_wrap;

  gray_counter #(.WIDTH(W), .INIT_BIN(INIT)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .clear_i    (clear),
    .load_i     (load),
    .load_val_i (load_val),
    .en_i       (en),
    .up_i       (up),
    .count_o    (count),
    .bin_o      (bin),
    .wrap_o     (wrap),
    .overflow_o (ovf),
    .underflow_o(udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int unsigned gray_of(input int unsigned v);
    return (v ^ (v >> 1)) % M;
  endfunction

  // Inverse Gray by exhaustive search over all values.
  function automatic int unsigned ungray(input logic [W-1:0] g);
    int unsigned r;
    r = 0;
    for (int v = 0; v < M; v++) begin
      if (gray_of(v) == g) r = v;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_val  = INIT;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_wrap = 1'b0;
  endfunction

  function automatic void model_step(input bit c, input bit l, input logic [W-1:0] lv,
                                     input bit e, input bit u);
    m_wrap = 1'b0;
    if (c) begin
      m_val = INIT;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (l) begin
      m_val = ungray(lv);
    end else if (e) begin
      if (u) begin
        if (m_val == M - 1) begin
          m_ovf  = 1'b1;
          m_wrap = 1'b1;
`ifndef GRAY_SAT_EN
          m_val  = 0;
`endif
        end else begin
          m_val = m_val + 1;
        end
      end else begin
        if (m_val == 0) begin
          m_udf  = 1'b1;
          m_wrap = 1'b1;
`ifndef GRAY_SAT_EN
          m_val  = M - 1;
`endif
        end else begin
          m_val = m_val - 1;
        end
      end
    end
  endfunction

  function automatic logic [2*W+2:0] exp_vec();
    logic [W-1:0] b;
    logic [W-1:0] g;
    b = W'(m_val);
    g = W'(gray_of(m_val));
    return {g, b, m_wrap, m_ovf, m_udf};
  endfunction

  function automatic logic [2*W+2:0] dut_vec();
    return {count, bin, wrap, ovf, udf};
  endfunction

  // Apply inputs for one edge, advance the model, sample 1 ns after the edge.
  task automatic cycle(input bit c, input bit l, input logic [W-1:0] lv,
                       input bit e, input bit u);
    clear    = c;
    load     = l;
    load_val = lv;
    en       = e;
    up       = u;
    @(posedge clk);
    model_step(c, l, lv, e, u);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_total++;
    if (dut_vec() !== exp_vec())
      $display("FAIL reset_state: got %b expected %b", dut_vec(), exp_vec());
    else n_pass++;
    #10 rst_n = 1'b1;   // released away from a clock edge
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 1);
    n_total++;
    if (count !== 3'b110) $display("FAIL pre_reset_count: got %b expected 110", count);
    else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (dut_vec() !== {3'b000, 3'b000, 3'b000})
      $display("FAIL async_reset: got %b expected %b", dut_vec(), {3'b000, 3'b000, 3'b000});
    else n_pass++;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_up_sequence();
    logic [W-1:0] seq [8];
    logic [W-1:0] prev;
    seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    cycle(1, 0, '0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      prev = count;
      cycle(0, 0, '0, 1, 1);
      n_total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL up_seq_model[%0d]: got %b expected %b", i, dut_vec(), exp_vec());
      else n_pass++;
`ifndef GRAY_SAT_EN
      n_total++;
      if (count !== seq[i] || wrap !== (i == 7) || $countones(prev ^ count) != 1)
        $display("FAIL up_seq[%0d]: got count=%b wrap=%b expected count=%b wrap=%b one-bit step",
                 i, count, wrap, seq[i], (i == 7));
      else n_pass++;
`endif
    end
  endtask

  task automatic test_down_wrap();
    cycle(1, 0, '0, 0, 0);
    cycle(0, 0, '0, 1, 0);
    n_total++;
    if (dut_vec() !== exp_vec())
      $display("FAIL down_wrap: got %b expected %b", dut_vec(), exp_vec());
    else n_pass++;
`ifndef GRAY_SAT_EN
    n_total++;
    if ({count, bin, wrap, ovf, udf} !== {3'b100, 3'b111, 1'b1, 1'b0, 1'b1})
      $display("FAIL down_wrap_vec: got %b expected %b", dut_vec(),
               {3'b100, 3'b111, 1'b1, 1'b0, 1'b1});
    else n_pass++;
`endif
    cycle(0, 0, '0, 0, 0);
    n_total++;
    if (wrap !== 1'b0 || udf !== 1'b1)
      $display("FAIL wrap_pulse_end: got wrap=%b udf=%b expected wrap=0 udf=1", wrap, udf);
    else n_pass++;
  endtask

  task automatic test_load_priority();
    cycle(0, 1, 3'b101, 1, 1);
    n_total++;
    if ({count, bin, wrap} !== {3'b101, 3'b110, 1'b0} || dut_vec() !== exp_vec())
      $display("FAIL load_over_en: got %b expected %b", dut_vec(), exp_vec());
    else n_pass++;
    cycle(0, 0, '0, 1, 1);
    n_total++;
    if ({count, bin} !== {3'b100, 3'b111} || dut_vec() !== exp_vec())
      $display("FAIL after_load_up: got %b expected %b", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_clear_priority();
    cycle(0, 1, 3'b100, 0, 0);
    cycle(0, 0, '0, 1, 1);
    n_total++;
    if (ovf !== 1'b1 || wrap !== 1'b1)
      $display("FAIL ovf_set: got ovf=%b wrap=%b expected 1 1", ovf, wrap);
    else n_pass++;
    cycle(0, 1, 3'b011, 0, 0);
    n_total++;
    if (ovf !== 1'b1 || dut_vec() !== exp_vec())
      $display("FAIL ovf_sticky_load: got %b expected %b", dut_vec(), exp_vec());
    else n_pass++;
    cycle(1, 1, 3'b111, 1, 1);
    n_total++;
    if ({count, wrap, ovf, udf} !== {3'b000, 1'b0, 1'b0, 1'b0} || dut_vec() !== exp_vec())
      $display("FAIL clear_over_all: got %b expected %b", dut_vec(), exp_vec());
    else n_pass++;
  endtask

`ifdef GRAY_SAT_EN
  task automatic test_saturate();
    cycle(0, 1, 3'b100, 0, 0);
    cycle(0, 0, '0, 1, 1);
    n_total++;
    if ({count, ovf, wrap} !== {3'b100, 1'b1, 1'b1})
      $display("FAIL sat_up: got count=%b ovf=%b wrap=%b expected 100 1 1", count, ovf, wrap);
    else n_pass++;
    cycle(0, 0, '0, 1, 0);
    n_total++;
    if ({count, wrap} !== {3'b101, 1'b0})
      $display("FAIL sat_down_after: got count=%b wrap=%b expected 101 0", count, wrap);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] prev;
    int unsigned  prev_val;
    bit c, l, e, u;
    logic [W-1:0] lv;
    for (int i = 0; i < 400; i++) begin
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 9) < 8);
      u  = $urandom_range(0, 1);
      lv = W'($urandom);
      prev     = count;
      prev_val = m_val;
      cycle(c, l, lv, e, u);
      n_total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random[%0d]: got %b expected %b", i, dut_vec(), exp_vec());
      else n_pass++;
      if (!c && !l && e) begin
        n_total++;
        if ($countones(prev ^ count) != ((prev_val == m_val) ? 0 : 1))
          $display("FAIL single_bit_step[%0d]: got %b -> %b expected one-bit change",
                   i, prev, count);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    en       = 1'b0;
    up       = 1'b0;
    model_reset();
    test_reset();
    test_async_reset();
    test_up_sequence();
    test_down_wrap();
    test_load_priority();
    test_clear_priority();
`ifdef GRAY_SAT_EN
    test_saturate();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
